// File: rtl/lab_bcd_pkg.sv
// rtl/lab_bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package lab_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int                         BCD_DIGIT_W    = 4;
    localparam logic [BCD_DIGIT_W-1:0]     BCD_ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0]     BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble add-3 adjust for one BCD digit
module bcd_digit_adj
    import lab_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // Largest input is 9, so 9+3=12 always fits in the digit width.
    assign adjusted = (digit >= BCD_ADJ_THRESH) ? digit + BCD_ADJ_ADD : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - one-bit-per-cycle shift-and-add-3 binary to BCD converter
module bin_to_bcd_seq
    import lab_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         RST_N,
    input  logic                         start,
    input  logic [WIDTH-1:0]             bin,
    output logic                         busy,
    output logic                         done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                         ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SW    = BCD_DIGIT_W * DIGITS;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0]    scratch;
    logic [SW-1:0]    adj;
    logic [WIDTH-1:0] shreg;
    logic             acc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CONV) || (state == DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            scratch <= '0;
            shreg   <= '0;
            acc     <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        acc     <= 1'b0;
                        cnt     <= CNT_W'(WIDTH);
                    end
                end
                CONV: begin
                    // Bit leaving the top digit is a lost 10^DIGITS carry.
                    scratch <= {adj[SW-2:0], shreg[WIDTH-1]};
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    acc     <= acc | adj[SW-1];
                    cnt     <= cnt - 1'b1;
                end
                DONE: begin
                    bcd  <= scratch;
                    ovf  <= acc;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    logic        CLOCK_50;
    logic        RST_N;
    logic        start, start2;
    logic [7:0]  bin, bin2;
    logic        busy, busy2;
    logic        done, done2;
    logic [11:0] bcd;
    logic [7:0]  bcd2;
    logic        ovf, ovf2;

    int errors = 0;
    int checks = 0;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .ovf      (ovf)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .start    (start2),
        .bin      (bin2),
        .busy     (busy2),
        .done     (done2),
        .bcd      (bcd2),
        .ovf      (ovf2)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_conv(input logic [7:0] v, output int lat, output int bcyc, output logic both);
        lat  = 0;
        bcyc = 0;
        both = 1'b0;
        @(negedge CLOCK_50);
        start = 1'b1;
        bin   = v;
        @(negedge CLOCK_50);
        start = 1'b0;
        bin   = 8'($urandom);
        while (!done && lat < 30) begin
            if (busy) bcyc++;
            @(negedge CLOCK_50);
            lat++;
        end
        if (busy && done) both = 1'b1;
    endtask

    task automatic run_conv2(input logic [7:0] v, output int lat);
        lat = 0;
        @(negedge CLOCK_50);
        start2 = 1'b1;
        bin2   = v;
        @(negedge CLOCK_50);
        start2 = 1'b0;
        while (!done2 && lat < 30) begin
            @(negedge CLOCK_50);
            lat++;
        end
    endtask

    initial begin
        int          lat, bcyc, ndone, cyc, t1, t2;
        logic        both;
        logic [11:0] r1, r2;

        RST_N  = 1'b0;
        start  = 1'b0;
        bin    = 8'd0;
        start2 = 1'b0;
        bin2   = 8'd0;
        repeat (2) @(negedge CLOCK_50);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd",  32'(bcd),  32'd0);
        chk("reset_ovf",  32'(ovf),  32'd0);
        RST_N = 1'b1;

        run_conv(8'd0, lat, bcyc, both);
        chk("zero_latency", 32'(lat), 32'd9);
        chk("zero_bcd", 32'(bcd), 32'h000);
        chk("zero_ovf", 32'(ovf), 32'd0);
        chk("zero_busy_done_overlap", 32'(both), 32'd0);
        @(negedge CLOCK_50);
        chk("zero_done_one_cycle", 32'(done), 32'd0);

        run_conv(8'd255, lat, bcyc, both);
        chk("max_latency", 32'(lat), 32'd9);
        chk("max_bcd", 32'(bcd), 32'h255);
        chk("max_ovf", 32'(ovf), 32'd0);
        chk("max_busy_cycles", 32'(bcyc), 32'd9);
        chk("max_busy_done_overlap", 32'(both), 32'd0);

        run_conv2(8'd100, lat);
        chk("d2_100_latency", 32'(lat), 32'd9);
        chk("d2_100_ovf", 32'(ovf2), 32'd1);
        chk("d2_100_bcd", 32'(bcd2), 32'h00);
        run_conv2(8'd99, lat);
        chk("d2_99_ovf", 32'(ovf2), 32'd0);
        chk("d2_99_bcd", 32'(bcd2), 32'h99);

        @(negedge CLOCK_50);
        start = 1'b1;
        bin   = 8'd42;
        @(negedge CLOCK_50);
        start = 1'b0;
        bin   = 8'd0;
        repeat (2) @(negedge CLOCK_50);
        start = 1'b1;
        bin   = 8'd7;
        @(negedge CLOCK_50);
        start = 1'b0;
        ndone = 0;
        r1    = '0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ndone++;
                r1 = bcd;
            end
            @(negedge CLOCK_50);
        end
        chk("ignore_done_count", 32'(ndone), 32'd1);
        chk("ignore_bcd", 32'(r1), 32'h042);

        @(negedge CLOCK_50);
        start = 1'b1;
        bin   = 8'd200;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #2 RST_N = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bcd",  32'(bcd),  32'd0);
        chk("abort_ovf",  32'(ovf),  32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge CLOCK_50);
        RST_N = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLOCK_50);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_conv(8'd9, lat, bcyc, both);
        chk("after_abort_bcd", 32'(bcd), 32'h009);
        chk("after_abort_latency", 32'(lat), 32'd9);

        @(negedge CLOCK_50);
        start = 1'b1;
        bin   = 8'd9;
        @(negedge CLOCK_50);
        bin = 8'd10;
        cyc = 0;
        t1  = -1;
        t2  = -1;
        r1  = '0;
        r2  = '0;
        while (t2 < 0 && cyc < 40) begin
            if (done) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    r1 = bcd;
                end else begin
                    t2 = cyc;
                    r2 = bcd;
                end
            end
            @(negedge CLOCK_50);
            cyc++;
        end
        start = 1'b0;
        chk("b2b_first_bcd", 32'(r1), 32'h009);
        chk("b2b_second_bcd", 32'(r2), 32'h010);
        chk("b2b_spacing", 32'(t2 - t1), 32'd10);
        repeat (12) @(negedge CLOCK_50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It sits directly upstream of the per-digit seven-segment decoder and feeds it one 4-bit BCD digit per HEX display. Because it produces those digits, the decoder only ever sees codes 0-9. Each conversion is started by a single request and takes a fixed number of cycles. The most recent result is held stable until the next conversion completes.

## Interface
- `WIDTH`, default 8: width of the binary input, and the number of iterations per conversion.
- `DIGITS`, default 3: number of BCD output digits.
- `CLOCK_50`  in  1: system clock. All state changes on the rising edge.
- `RST_N`  in  1: reset, asynchronous and active-low.
- `start`  in  1: conversion request, sampled only in IDLE.
- `bin`  in  WIDTH: binary value, captured on the edge that accepts `start`.
- `busy`  out  1: high while a conversion is in progress (CONV or DONE state).
- `done`  out  1: one-cycle pulse when `bcd` and `ovf` have just been updated.
- `bcd`  out  4*DIGITS: packed BCD result. Digit 0 (ones) is in bits [3:0].
- `ovf`  out  1: high when the value captured for the last conversion exceeds 10^DIGITS-1.

## Operation
- FSM states: IDLE, CONV, DONE. Reset state is IDLE.
- IDLE with `start`=1:
  - Load the shift register with `bin`.
  - Clear the BCD scratch register and the overflow accumulator.
  - Set the iteration counter to WIDTH and go to CONV.
- IDLE with `start`=0: hold all state.
- CONV, each cycle:
  - Every scratch digit >= 5 gets +3 (combinational adjust).
  - Shift {scratch, shift register} left by 1.
  - OR the bit shifted out of the top digit into the overflow accumulator.
  - Decrement the counter. When the counter goes 1 -> 0, go to DONE.
- DONE, one cycle:
  - Load `bcd` from scratch and `ovf` from the accumulator.
  - Assert `done` and return to IDLE.
- `start` is ignored in CONV and DONE. Dropped requests are not queued.
- Overflow:
  - `bcd` = value mod 10^DIGITS; `ovf`=1.
  - With the defaults (8-bit input, 3 digits) overflow is impossible, so `ovf` stays 0.
- Arithmetic:
  - Adjust is per 4-bit digit with no inter-digit carry. The adjusted digit is always <= 12, so it fits in 4 bits.
  - Counter width is clog2(WIDTH+1).
- `bcd` and `ovf` are registered. They change only at the DONE edge, never during CONV.
- Reset values: `busy`=0, `done`=0, `bcd`=0, `ovf`=0. Counter, scratch and shift register are all 0.
- Reset mid-conversion: abort immediately and go to IDLE with the reset values. No `done` is produced.

## Timing
- Edge E0 accepts `start` in IDLE. `busy` is high from E0.
- Iterations occur on edges E1..E_WIDTH.
- Edge E_(WIDTH+1) updates `bcd` and `ovf` and asserts `done`.
  - `done` is high for exactly the one cycle following that edge.
  - `busy` falls at that same edge.
- Total latency from the accepting edge to `done` visible: WIDTH+1 edges. This is 9 edges with the defaults.
- `start` held high while `done` is high is accepted on the next edge.
  - Minimum back-to-back period is WIDTH+2 cycles.
- `busy` and `done` are never high in the same cycle.
- `bin` may change freely after E0 without affecting the result.

## Structure
- Package `lab_bcd_pkg` holds:
  - the FSM state encoding (IDLE=2'd0, CONV=2'd1, DONE=2'd2);
  - `BCD_DIGIT_W`=4;
  - `BCD_ADJ_THRESH`=5;
  - `BCD_ADJ_ADD`=3.
- One combinational sub-module, `bcd_digit_adj`: a 4-bit digit in, the adjusted 4-bit digit out.
  - It is instantiated DIGITS times in a generate loop.
- Everything else lives in the top level: FSM, counter, scratch and shift registers, output registers.

## Test plan
- Reset, then `bin`=0 and `start` pulse:
  - `done` appears after 9 edges;
  - `bcd`=12'h000, `ovf`=0.
- `bin`=8'd255 with `start`:
  - `bcd`=12'h255 at `done`, `ovf`=0;
  - `busy` is high for exactly 9 cycles.
- Parameters WIDTH=8, DIGITS=2, `bin`=8'd100:
  - `ovf`=1, `bcd`=8'h00.
- Then `bin`=8'd99:
  - `ovf`=0, `bcd`=8'h99.
- `bin`=8'd42 with `start`, then `start` pulsed again with `bin`=8'd7 during CONV:
  - exactly one `done`, with `bcd`=12'h042.
- Conversion of 8'd200 started, RST_N low at the 4th CONV cycle:
  - outputs go to 0 asynchronously;
  - no `done` is produced;
  - a new start with 8'd9 gives `bcd`=12'h009.
- `start` held high continuously with `bin` stepping 9 then 10:
  - successive `done` pulses exactly 10 cycles apart;
  - `bcd`=12'h009, then 12'h010.
